// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit driver: FSM encoding,
// register offsets and status-word bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [1:0] ADDR_TX_DATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_FULL_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;

  // Assemble the 16-bit status word; unused upper bits read as zero.
  function automatic logic [15:0] pack_status(input logic ovf,
                                              input logic full,
                                              input logic empty,
                                              input logic busy);
    logic [15:0] s;
    s                 = 16'h0000;
    s[STAT_OVF_BIT]   = ovf;
    s[STAT_FULL_BIT]  = full;
    s[STAT_EMPTY_BIT] = empty;
    s[STAT_BUSY_BIT]  = busy;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO: circular read/write pointers plus an occupancy count.
// A push while full is accepted only when a pop happens on the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Qualify push/pop and compute next pointer and count values.
  always_comb begin
    push_ok_s = push_i & (~full_o | pop_i);
    pop_ok_s  = pop_i & ~empty_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/uart_tx_driver.sv
// Memory-mapped 8N1 UART transmitter: a write to the data offset queues a
// byte, the bit FSM serialises queued bytes back to back, and the status
// offset reports overflow/full/empty/busy.
module uart_tx_driver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 200,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        iCpuClock,
  input  logic        iCpuResetN,
  input  logic        iDoIOWrite,
  input  logic        iDoIORead,
  input  logic        iDoUartAccess,
  input  logic [1:0]  iUartAddress,
  input  logic [15:0] iUartDataToWrite,
  output logic [15:0] oUartReadData,
  output logic        oFpgaUartToPc,
  output logic        oUartBusy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          line_q, line_d;
  logic          ovf_q, ovf_d;

  logic          push_s;
  logic          pop_s;
  logic          rd_s;
  logic          ovf_evt_s;
  logic          bit_done_s;
  logic [2:0]    idx_inc_s;
  logic [7:0]    fifo_head_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic          busy_s;
  logic [15:0]   rdata_s;
  logic          unused_wdata_s;

  assign unused_wdata_s = &{1'b0, iUartDataToWrite[15:8]};

  assign push_s     = iDoIOWrite & iDoUartAccess & (iUartAddress == ADDR_TX_DATA);
  assign rd_s       = iDoIORead & iDoUartAccess & (iUartAddress == ADDR_STATUS);
  assign bit_done_s = (cnt_q == BIT_LAST);
  assign idx_inc_s  = idx_q + 3'd1;
  assign ovf_evt_s  = push_s & fifo_full_s & ~pop_s;
  assign busy_s     = (state_q != ST_IDLE) | (fifo_count_s != {CW{1'b0}});

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (iCpuClock),
    .rst_ni  (iCpuResetN),
    .push_i  (push_s),
    .data_i  (iUartDataToWrite[7:0]),
    .pop_i   (pop_s),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Bit FSM: next state, bit timing, FIFO pop and next line level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    line_d  = line_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_head_s;
          cnt_d   = 16'd0;
          state_d = ST_START;
          line_d  = 1'b0;
        end else begin
          line_d  = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
          line_d  = shift_q[0];
          state_d = ST_DATA;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          cnt_d = 16'd0;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            line_d  = 1'b1;
          end else begin
            idx_d   = idx_inc_s;
            line_d  = shift_q[idx_inc_s];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_done_s) begin
          cnt_d = 16'd0;
          // Chain straight into the next frame when more bytes are queued.
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = fifo_head_s;
            state_d = ST_START;
            line_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
            line_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = 1'b1;
      end
    endcase
  end

  // Sticky overflow: a dropped push outranks the clear from a status read.
  always_comb begin
    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (rd_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Status read mux; bus reads zero unless the status offset is selected.
  always_comb begin
    if (rd_s) begin
      rdata_s = pack_status(ovf_q, fifo_full_s, fifo_empty_s, busy_s);
    end else begin
      rdata_s = 16'h0000;
    end
  end

  // FSM, timing and line registers with synchronous active-low reset.
  always_ff @(posedge iCpuClock) begin
    if (!iCpuResetN) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      line_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oFpgaUartToPc = line_q;
  assign oUartBusy     = busy_s;
  assign oUartReadData = rdata_s;

endmodule

// File: tb/tb_uart_tx_driver.sv
// Self-checking bench for uart_tx_driver: directed scenarios plus random
// bus traffic, all compared against a frame-level reference model.
module tb_uart_tx_driver;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr;
  logic        rd;
  logic        acc;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        line;
  logic        busy;

  always #5 clk = ~clk;

  uart_tx_driver #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .iCpuClock        (clk),
    .iCpuResetN       (rst_n),
    .iDoIOWrite       (wr),
    .iDoIORead        (rd),
    .iDoUartAccess    (acc),
    .iUartAddress     (addr),
    .iUartDataToWrite (wdata),
    .oUartReadData    (rdata),
    .oFpgaUartToPc    (line),
    .oUartBusy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queued bytes, sticky overflow, and the frame in flight
  // described by its start cycle and byte value.
  logic [7:0]  m_q[$];
  bit          m_ovf    = 1'b0;
  bit          m_active = 1'b0;
  int          m_start  = 0;
  int          m_cyc    = 0;
  logic [7:0]  m_byte   = 8'h00;
  logic [15:0] last_rd;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  function automatic logic [15:0] m_status();
    int v;
    v = (m_ovf ? 8 : 0) + ((m_q.size() == DEPTH) ? 4 : 0) +
        ((m_q.size() == 0) ? 2 : 0) + ((m_active || m_q.size() != 0) ? 1 : 0);
    return 16'(v);
  endfunction

  function automatic logic m_line();
    int b;
    if (!m_active) return 1'b1;
    b = (m_cyc - m_start) / CPB;
    if (b == 0) return 1'b0;
    else if (b <= 8) return m_byte[b-1];
    else return 1'b1;
  endfunction

  task automatic m_edge(input bit rstn, input bit push, input bit rdst, input logic [7:0] d);
    int pre;
    bit popped;
    bit ovf_evt;
    m_cyc++;
    if (!rstn) begin
      m_q.delete();
      m_ovf    = 1'b0;
      m_active = 1'b0;
      return;
    end
    pre     = m_q.size();
    popped  = 1'b0;
    ovf_evt = 1'b0;
    if (!m_active || (m_cyc - m_start == 10 * CPB)) begin
      if (pre != 0) begin
        m_byte   = m_q.pop_front();
        m_active = 1'b1;
        m_start  = m_cyc;
        popped   = 1'b1;
      end else begin
        m_active = 1'b0;
      end
    end
    if (push) begin
      if (pre < DEPTH || popped) m_q.push_back(d);
      else ovf_evt = 1'b1;
    end
    if (ovf_evt) m_ovf = 1'b1;
    else if (rdst) m_ovf = 1'b0;
  endtask

  // One clock: drive inputs, check read data before the edge, then line/busy after.
  task automatic step(input bit rstn, input bit w, input bit r, input bit a,
                      input logic [1:0] ad, input logic [15:0] wd);
    logic [15:0] exp_rd;
    rst_n = rstn; wr = w; rd = r; acc = a; addr = ad; wdata = wd;
    @(negedge clk);
    exp_rd  = (r && a && ad == 2'd2) ? m_status() : 16'h0000;
    last_rd = rdata;
    check_eq("rdata", rdata, exp_rd);
    @(posedge clk);
    m_edge(rstn, w && a && ad == 2'd0, r && a && ad == 2'd2, wd[7:0]);
    #1;
    check_eq("line", {15'd0, line}, {15'd0, m_line()});
    check_eq("busy", {15'd0, busy}, {15'd0, (m_active || m_q.size() != 0)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, {8'h5A, b});
  endtask

  task automatic rd_status();
    step(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 16'h0000);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 600) begin
      idle(1);
      n++;
    end
    check_eq(tag, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    logic pat [10];
    int   n0;
    int   n;
    bit   found;
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; acc = 1'b0; addr = 2'd0; wdata = 16'h0000;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    rd_status();
    check_eq("reset_status", last_rd, 16'h0002);

    // Single byte A5: bit pattern and busy-fall timing
    wr_byte(8'hA5);
    for (int j = 1; j <= 44; j++) begin
      idle(1);
      if (j <= 40 && ((j - 1) % 4) == 1) check_eq("a5_bit", {15'd0, line}, {15'd0, pat[(j-1)/4]});
      if (j == 40) check_eq("a5_busy_hi", {15'd0, busy}, 16'd1);
      if (j == 41) check_eq("a5_busy_lo", {15'd0, busy}, 16'd0);
    end

    // Five back-to-back writes: FIFO fills, frames chain without gaps
    wr_byte(8'h01);
    n0 = m_cyc;
    for (int i = 2; i <= 5; i++) wr_byte(8'(i));
    rd_status();
    check_eq("five_full", {15'd0, last_rd[2]}, 16'd1);
    check_eq("five_noovf", {15'd0, last_rd[3]}, 16'd0);
    n = 0;
    while (busy !== 1'b0 && n < 600) begin
      idle(1);
      n++;
    end
    check_eq("five_span", 16'(m_cyc - n0), 16'(1 + 5 * 10 * CPB));

    // Six writes while a frame is in flight: sixth dropped, overflow sticky until read
    for (int i = 1; i <= 6; i++) wr_byte(8'(8'h10 + i));
    rd_status();
    check_eq("ovf_set", {15'd0, last_rd[3]}, 16'd1);
    check_eq("ovf_full", {15'd0, last_rd[2]}, 16'd1);
    check_eq("ovf_busy", {15'd0, last_rd[0]}, 16'd1);
    rd_status();
    check_eq("ovf_clr", {15'd0, last_rd[3]}, 16'd0);
    wait_idle("ovf_drain");

    // Push into a full FIFO on the edge where the stop bit ends and pops
    for (int i = 1; i <= 5; i++) wr_byte(8'(8'h20 + i));
    n = 0;
    found = (m_active && (m_cyc + 1 - m_start == 10 * CPB));
    while (!found && n < 100) begin
      idle(1);
      n++;
      found = (m_active && (m_cyc + 1 - m_start == 10 * CPB));
    end
    check_eq("stop_edge_reached", {15'd0, found}, 16'd1);
    wr_byte(8'h77);
    rd_status();
    check_eq("stop_push_noovf", {15'd0, last_rd[3]}, 16'd0);
    check_eq("stop_push_full", {15'd0, last_rd[2]}, 16'd1);
    wait_idle("stop_drain");

    // Reset in the middle of the data bits with bytes still queued
    wr_byte(8'h3C);
    wr_byte(8'h11);
    wr_byte(8'h22);
    n = 0;
    found = (m_active && ((m_cyc - m_start) / CPB) == 4);
    while (!found && n < 100) begin
      idle(1);
      n++;
      found = (m_active && ((m_cyc - m_start) / CPB) == 4);
    end
    check_eq("mid_data_reached", {15'd0, found}, 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    check_eq("rst_line_hi", {15'd0, line}, 16'd1);
    rd_status();
    check_eq("rst_status", last_rd, 16'h0002);
    idle(60);
    check_eq("rst_no_frames", {15'd0, busy}, 16'd0);

    // Other offsets: writes ignored, reads return zero
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 16'h00FF);
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 16'h00EE);
    check_eq("offs_no_push", {15'd0, busy}, 16'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0000);
    check_eq("rd_off0", last_rd, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 16'h0000);
    check_eq("rd_off1", last_rd, 16'h0000);

    // Random bus traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)),
           16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
